stopwatch_ctrl: RTL and testbench

Control sequencer for the two-digit Stopwatch datapath (00-99 BCD counter driving the digit1/digit2 seven-segment outputs). It debounces the raw start/stop and lap buttons and runs an IDLE/RUN/LAP/PAUSE state machine. It also generates the prescaled count tick and the clear strobe for the datapath. A display mux selects either the live count or a frozen lap value.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/stopwatch_ctrl.sv | 105 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch control sequencer.
package stopwatch_pkg;

  localparam int unsigned BcdW              = 8;
  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefTickDiv        = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StLap   = 2'b10,
    StPause = 2'b11
  } sw_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-counter debouncer and one-cycle press pulse
// for a raw, bouncing push button.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            s1_q, s2_q;
  logic            db_q, db_d, db_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      // Flip on the edge where the count would reach DEBOUNCE_CYCLES.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debouncing, IDLE/RUN/LAP/PAUSE FSM,
// count-tick prescaler and lap-freeze display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned TICK_DIV        = DefTickDiv
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            btn_start_i,
  input  logic            btn_lap_i,
  input  logic [BcdW-1:0] count_in_i,
  output logic            tick_o,
  output logic            count_clr_o,
  output logic            running_o,
  output logic            freeze_o,
  output logic [BcdW-1:0] disp_bcd_o,
  output logic [1:0]      state_o
);

  localparam int unsigned PreW = $clog2(TICK_DIV);

  sw_state_e       state_q, state_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic [BcdW-1:0] lap_q, lap_d;
  logic            start_press, lap_press_raw, lap_press;
  logic            running, presc_last;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .btn_i  (btn_start_i),
    .press_o(start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_lap (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .btn_i  (btn_lap_i),
    .press_o(lap_press_raw)
  );

  // Start wins a same-cycle collision; the lap press is dropped.
  assign lap_press  = lap_press_raw & ~start_press;
  assign running    = (state_q == StRun) || (state_q == StLap);
  assign presc_last = (presc_q == PreW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      StIdle: begin
        if (start_press) state_d = StRun;
      end
      StRun: begin
        if (start_press) begin
          state_d = StPause;
        end else if (lap_press) begin
          state_d = StLap;
          lap_d   = count_in_i;
        end
      end
      StLap: begin
        if (start_press)    state_d = StPause;
        else if (lap_press) state_d = StRun;
      end
      StPause: begin
        if (start_press)    state_d = StRun;
        else if (lap_press) state_d = StIdle;
      end
    endcase

    presc_d = presc_q;
    if (state_d == StIdle) begin
      presc_d = '0;
    end else if (running) begin
      presc_d = presc_last ? '0 : presc_q + PreW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      presc_q <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
    end
  end

  assign tick_o      = running & presc_last;
  assign count_clr_o = (state_q == StIdle);
  assign running_o   = running;
  assign freeze_o    = (state_q == StLap);
  assign state_o     = state_q;
  assign disp_bcd_o  = freeze_o ? lap_q : count_in_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int unsigned Db = 4;
  localparam int unsigned Td = 10;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       btn_start_i;
  logic       btn_lap_i;
  logic [7:0] count_in_i;
  logic       tick_o;
  logic       count_clr_o;
  logic       running_o;
  logic       freeze_o;
  logic [7:0] disp_bcd_o;
  logic [1:0] state_o;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(Db),
    .TICK_DIV       (Td)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .btn_start_i(btn_start_i),
    .btn_lap_i  (btn_lap_i),
    .count_in_i (count_in_i),
    .tick_o     (tick_o),
    .count_clr_o(count_clr_o),
    .running_o  (running_o),
    .freeze_o   (freeze_o),
    .disp_bcd_o (disp_bcd_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0=IDLE 1=RUN 2=LAP 3=PAUSE
  int          m_state;
  logic [7:0]  m_lap;
  int          m_runcyc;
  bit          m_db    [2];
  bit          m_press [2];
  logic [Db+1:0] m_hist [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state  = 0;
    m_lap    = 8'h00;
    m_runcyc = 0;
    for (int b = 0; b < 2; b++) begin
      m_db[b]    = 1'b0;
      m_press[b] = 1'b0;
      m_hist[b]  = '0;
    end
  endfunction

  function automatic void model_edge(input bit rs, input bit rl, input logic [7:0] cin);
    bit sp, lp, run, stable, raw;
    int nxt;
    sp  = m_press[0];
    lp  = m_press[1] && !sp;
    run = (m_state == 1) || (m_state == 2);
    if (run) m_runcyc++;
    nxt = m_state;
    case (m_state)
      0: if (sp) nxt = 1;
      1: if (sp) nxt = 3; else if (lp) begin nxt = 2; m_lap = cin; end
      2: if (sp) nxt = 3; else if (lp) nxt = 1;
      default: if (sp) nxt = 1; else if (lp) nxt = 0;
    endcase
    if (nxt == 0) m_runcyc = 0;
    m_state = nxt;
    // A button level flips once the synchronized samples have disagreed with it
    // for Db consecutive cycles; synchronized value lags the raw sample by two edges.
    for (int b = 0; b < 2; b++) begin
      raw       = (b == 0) ? rs : rl;
      m_hist[b] = {m_hist[b][Db:0], raw};
      stable    = 1'b1;
      for (int j = 2; j <= Db + 1; j++) begin
        if (m_hist[b][j] == m_db[b]) stable = 1'b0;
      end
      m_press[b] = 1'b0;
      if (stable) begin
        m_db[b]    = !m_db[b];
        m_press[b] = m_db[b];
      end
    end
  endfunction

  task automatic check_outputs();
    bit run, frz;
    run = (m_state == 1) || (m_state == 2);
    frz = (m_state == 2);
    check_eq("state", 32'(state_o), 32'(m_state));
    check_eq("running", 32'(running_o), 32'(run));
    check_eq("freeze", 32'(freeze_o), 32'(frz));
    check_eq("count_clr", 32'(count_clr_o), 32'(m_state == 0));
    check_eq("tick", 32'(tick_o), 32'(run && ((m_runcyc % Td) == Td - 1)));
    check_eq("disp_bcd", 32'(disp_bcd_o), 32'(frz ? m_lap : count_in_i));
  endtask

  task automatic rand_count();
    count_in_i = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endtask

  task automatic step(input bit rs, input bit rl);
    rand_count();
    btn_start_i = rs;
    btn_lap_i   = rl;
    @(posedge clk_i);
    model_edge(rs, rl, count_in_i);
    @(negedge clk_i);
    check_outputs();
  endtask

  // Asynchronous reset mid-operation: outputs must drop before the next edge.
  task automatic async_reset();
    btn_start_i = 1'b0;
    btn_lap_i   = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk_i);
    @(negedge clk_i);
    check_outputs();
    reset_i = 1'b0;
  endtask

  initial begin
    int sel, len, gap;
    bit rs, rl;
    reset_i     = 1'b1;
    btn_start_i = 1'b0;
    btn_lap_i   = 1'b0;
    rand_count();
    model_reset();
    repeat (20) begin
      @(negedge clk_i);
      rand_count();
      #1 check_outputs();
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (3) step(1'b0, 1'b0);

    // Short glitch train on start must not register as a press.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);

    for (int s = 0; s < 300; s++) begin
      sel = int'($urandom_range(0, 5));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, Db - 1))
                                        : int'($urandom_range(Db, 14));
      rs  = (sel <= 1) || (sel == 4);
      rl  = (sel == 2) || (sel == 3) || (sel == 4);
      for (int i = 0; i < len; i++) step(rs, rl);
      gap = int'($urandom_range(1, 25));
      for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
      if ($urandom_range(0, 39) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
